mul3: RTL and testbench
=======================

MUL3 -- requirements
Module: mul3

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port `start`, input, 1 bit: request to reconstruct a dividend.
REQ-004 SHALL have port `q`, input, 8 bits: quotient, unsigned.
REQ-005 SHALL have port `r`, input, 2 bits: remainder, unsigned; legal values 0..2.
REQ-006 SHALL have port `busy`, output, 1 bit: high while computing.
REQ-007 SHALL have port `done`, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port `err`, output, 1 bit: last accepted request had r == 3.
REQ-009 SHALL have port `n`, output, 10 bits: reconstructed dividend, n = 3*q + r, unsigned.

Function
REQ-010 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-011 SHALL accept `start` only when the state is IDLE or DONE; `q` and `r` SHALL be captured into internal registers on the accepting edge.
REQ-012 SHALL, on an accepted start with r <= 2:
- set acc = r (zero-extended to 10 bits);
- set the bit counter to 0;
- go to CALC.
REQ-013 SHALL, in CALC, process one captured q bit per edge, LSB first: if q[k] = 1 then acc += 3 << k (10-bit add), then k = k + 1.
REQ-014 SHALL, on the CALC edge that processes k = 7, load `n` from the final acc, go to DONE, and clear `err`.
REQ-015 SHALL have a latency of exactly 8 edges from the accepting edge to DONE; `done` SHALL be high during the cycle following that 8th edge.
REQ-016 SHALL, on an accepted start with r = 3:
- skip CALC and go to DONE on the accepting edge;
- set n = 0 and err = 1;
- `done` is then high on the next cycle.
REQ-017 SHALL keep `busy` = 1 exactly while the state is CALC, and 0 in IDLE and DONE.
REQ-018 SHALL keep `done` = 1 exactly while the state is DONE, which lasts one cycle.
REQ-019 SHALL, from DONE, go to IDLE when `start` is low; if `start` is high, it SHALL accept the new request per REQ-012 or REQ-016.
REQ-020 SHALL ignore `start` in CALC; captured operands SHALL NOT change mid-operation.
REQ-021 SHALL hold `n` and `err` stable from completion until the next completion; they SHALL NOT change during CALC.
REQ-022 SHALL never overflow the 10-bit acc: the maximum result is 3*255 + 2 = 767 < 1024, and no saturation or wrap logic is required.
REQ-023 SHALL treat `q` and `r` as don't-care when no start is accepted.

Reset
REQ-024 SHALL, while `rst` = 1, immediately (without waiting for `clk`) force:
- state = IDLE;
- busy = 0, done = 0, err = 0;
- n = 0, acc = 0, counter = 0.
REQ-025 SHALL abort any in-progress CALC on reset; no `done` pulse SHALL be produced for the aborted request.
REQ-026 SHALL accept a start on the first rising edge after `rst` deasserts.

Verification
REQ-027 SHALL be verified with the scenario: reset, then start with q=0, r=0 -> done 8 cycles later, n=0, err=0.
REQ-028 SHALL be verified with the scenario: start with q=255, r=2 -> busy high for 8 cycles, then done with n=767.
REQ-029 SHALL be verified with the scenario: start with q=5, r=1 -> n=16; then start again during the DONE cycle with q=10, r=2 -> no IDLE gap, n=32 after 8 more edges.
REQ-030 SHALL be verified with the scenario: start with q=7, r=3 -> done on the next cycle with err=1 and n=0, and busy never rises.
REQ-031 SHALL be verified with the scenario: start with q=100, r=0, then pulse start with q=1, r=1 during CALC -> the pulse is ignored and n=300.
REQ-032 SHALL be verified with the scenario: start with q=200, r=1, assert rst at CALC k=4 -> outputs zero immediately, no done pulse; then after release, start with q=3, r=0 -> n=9.

Source files
------------

// File: rtl/mul3.sv
// Reconstructs a dividend n = 3*q + r by serial shift-and-add over the 8 quotient bits.
// Three-state FSM: IDLE -> CALC (8 edges) -> DONE (1 cycle); r == 3 is flagged and skips CALC.
module mul3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] q,
  input  logic [1:0] r,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [9:0] n
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  qop_q, qop_d;
  logic [9:0]  acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  n_q, n_d;
  logic        err_q, err_d;
  logic [9:0]  addend;
  logic [9:0]  acc_nxt;

  // 3 << k fits in 10 bits for k <= 7, and 3*255 + 2 = 767, so acc never wraps
  assign addend  = qop_q[cnt_q] ? (10'd3 << cnt_q) : 10'd0;
  assign acc_nxt = acc_q + addend;

  always_comb begin
    state_d = state_q;
    qop_d   = qop_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          qop_d = q;
          cnt_d = 3'd0;
          if (r == 2'd3) begin
            acc_d   = 10'd0;
            n_d     = 10'd0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            acc_d   = {8'd0, r};
            state_d = CALC;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          n_d     = acc_nxt;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      qop_q   <= 8'd0;
      acc_q   <= 10'd0;
      cnt_q   <= 3'd0;
      n_q     <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qop_q   <= qop_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign n    = n_q;

endmodule

// File: tb/tb_mul3.sv
// Directed bench for mul3: latency, busy window, back-to-back starts, r==3 error path,
// ignored start during CALC, and asynchronous abort.
module tb_mul3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] q;
  logic [1:0] r;
  logic       busy, done, err;
  logic [9:0] n;

  int total = 0;
  int bad   = 0;

  mul3 dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .r(r),
    .busy(busy), .done(done), .err(err), .n(n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Issues a start, optionally pulses a second start pulse_at cycles into CALC,
  // then counts edges to done and busy cycles. Leaves the DUT in DONE.
  task automatic run_op(input string tg, input logic [7:0] qv, input logic [1:0] rv,
                        input int pulse_at, input logic [9:0] en, input logic ee, input int elat);
    int lat, nbusy;
    logic [9:0] prev_n;
    logic       prev_e;
    logic       chg;
    prev_n = n;
    prev_e = err;
    chg    = 1'b0;
    start = 1'b1; q = qv; r = rv;
    @(posedge clk); #1;
    start = 1'b0; q = 8'($urandom); r = 2'($urandom);
    lat = 0; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (n !== prev_n || err !== prev_e) chg = 1'b1;
      if (lat == pulse_at) begin start = 1'b1; q = 8'd1; r = 2'd1; end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk({tg, "_lat"},  lat,   elat);
    chk({tg, "_busy"}, nbusy, elat);
    chk({tg, "_hold"}, chg,   1'b0);
    chk({tg, "_n"},    n,     en);
    chk({tg, "_err"},  err,   ee);
  endtask

  initial begin
    int cnt_done;
    rst = 1'b1; start = 1'b0; q = 8'd0; r = 2'd0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err",  err,  1'b0);
    chk("rst_n",    n,    10'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // start on the first edge after reset release
    run_op("zero", 8'd0, 2'd0, -1, 10'd0, 1'b0, 8);
    @(posedge clk); #1;
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);

    run_op("max", 8'd255, 2'd2, -1, 10'd767, 1'b0, 8);
    @(posedge clk); #1;

    // back-to-back: second start issued during the DONE cycle
    run_op("b2b_a", 8'd5, 2'd1, -1, 10'd16, 1'b0, 8);
    run_op("b2b_b", 8'd10, 2'd2, -1, 10'd32, 1'b0, 8);
    @(posedge clk); #1;

    run_op("r3", 8'd7, 2'd3, -1, 10'd0, 1'b1, 0);
    @(posedge clk); #1;

    // start pulse mid-CALC must be ignored; also clears the earlier err
    run_op("ign", 8'd100, 2'd0, 3, 10'd300, 1'b0, 8);
    @(posedge clk); #1;

    // abort at k=4
    start = 1'b1; q = 8'd200; r = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_n",    n,    10'd0);
    chk("abort_err",  err,  1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_done = 0;
    repeat (12) begin
      if (done) cnt_done++;
      @(posedge clk); #1;
    end
    chk("abort_nodone", cnt_done, 0);

    run_op("post", 8'd3, 2'd0, -1, 10'd9, 1'b0, 8);
    @(posedge clk); #1;
    chk("post_idle", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
